alu_share_arbiter: RTL

//  - Shares one combinational ALU (32-bit, 4-bit op) between two requesters, e.g. the main datapath and a helper unit.
//  - Round-robin arbitration; valid/ready on the request side and valid/ready on the response side.
//  - Operands and result are registered; the ALU itself stays outside this block.

---
 rtl/alu_share_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
    parameter int unsigned        DATA_W  = 32,
    parameter int unsigned        OP_W    = 4,
    parameter logic [OP_W-1:0]    IDLE_OP = 4'hF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              id_q;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic [OP_W-1:0]   op_q;

    logic              accept;
    logic              winner;
    logic              resp_hs;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        winner  = 1'b0;
        resp_hs = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept  = 1'b1;
                    // Sole requester wins; on contention the one not served last wins.
                    winner  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (id_q ? resp1_ready : resp0_ready) begin
                    resp_hs = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q <= winner;
                a_q  <= winner ? req1_a  : req0_a;
                b_q  <= winner ? req1_b  : req0_b;
                op_q <= winner ? req1_op : req0_op;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
            end
            if (resp_hs) begin
                last_grant_q <= id_q;
            end
        end
    end

    assign req0_ready   = accept && !winner;
    assign req1_ready   = accept &&  winner;
    assign resp0_valid  = (state_q == RESP) && !id_q;
    assign resp1_valid  = (state_q == RESP) &&  id_q;
    assign resp0_result = result_q;
    assign resp1_result = result_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = (state_q == EXEC) ? op_q : IDLE_OP;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
            if (req1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule
